// File: rtl/fifo_test_pkg.sv
// Shared types and widths for the FIFO traffic generator and its checker.
package fifo_test_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LVL_W  = 9;
    localparam int unsigned ERR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // First mismatch record, packed as {expected, received}.
    typedef struct packed {
        logic [DATA_W-1:0] expected;
        logic [DATA_W-1:0] received;
    } err_rec_t;

endpackage

// File: rtl/fifo_test_gen_if.sv
// FIFO write/read port bundle between the traffic generator and the FIFO.
interface fifo_test_gen_if;
    import fifo_test_pkg::*;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_empty;
    logic [LVL_W-1:0]  rd_water_level;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, rd_data, rd_empty, rd_water_level
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, rd_data, rd_empty, rd_water_level
    );

endinterface

// File: rtl/fifo_data_checker.sv
// Compares returned FIFO bytes with the expected pattern; saturating error count
// and first-mismatch capture.
module fifo_data_checker
    import fifo_test_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chk_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              mismatch_c,
    output logic [ERR_W-1:0]  err_cnt,
    output err_rec_t          first_err
);

    assign mismatch_c = chk_vld && (rd_data != exp_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            first_err <= '0;
        end else if (mismatch_c) begin
            if (err_cnt == '0) begin
                first_err.expected <= exp_data;
                first_err.received <= rd_data;
            end
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_test_gen.sv
// Self-checking FIFO traffic generator: writes an incrementing byte burst, waits
// for the FIFO to fill, drains it and checks the returned pattern.
module fifo_test_gen
    import fifo_test_pkg::*;
#(
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned ROUNDS    = 4,
    parameter int unsigned INIT_WAIT = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    fifo_test_gen_if.master       fifo,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [2*DATA_W-1:0]   first_err
);

    localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
    localparam int unsigned INIT_W = (INIT_WAIT > 0) ? $clog2(INIT_WAIT + 1) : 1;
    localparam int unsigned TIM_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned RND_W  = (ROUNDS > 0) ? $clog2(ROUNDS + 1) : 1;

    state_t            state, state_d;
    logic [INIT_W-1:0] init_cnt, init_cnt_d;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt, rd_cnt_d;
    logic [TIM_W-1:0]  wait_cnt, wait_cnt_d;
    logic [RND_W-1:0]  round_cnt, round_cnt_d;
    logic              wr_en, wr_en_d;
    logic [DATA_W-1:0] wr_data, wr_data_d;
    logic              rd_en, rd_en_d;
    logic              chk_vld, chk_vld_d;
    logic [DATA_W-1:0] exp_data, exp_data_d;
    logic              done_d, pass_d, timeout_d;
    logic              wr_acc_c, rd_acc_c, mismatch_c;
    err_rec_t          first_err_rec;

    assign fifo.wr_en   = wr_en;
    assign fifo.wr_data = wr_data;
    assign fifo.rd_en   = rd_en;
    assign first_err    = first_err_rec;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        init_cnt_d  = init_cnt;
        wr_cnt_d    = wr_cnt;
        rd_cnt_d    = rd_cnt;
        wait_cnt_d  = wait_cnt;
        round_cnt_d = round_cnt;
        wr_en_d     = wr_en;
        wr_data_d   = wr_data;
        rd_en_d     = rd_en;
        done_d      = done;
        pass_d      = pass;
        timeout_d   = timeout;

        wr_acc_c   = wr_en && !fifo.wr_full;
        rd_acc_c   = rd_en && !fifo.rd_empty;
        chk_vld_d  = rd_acc_c;
        exp_data_d = chk_vld ? exp_data + DATA_W'(1) : exp_data;

        case (state)
            ST_IDLE: begin
                if (32'(init_cnt) + 32'd1 >= INIT_WAIT) begin
                    state_d  = ST_WRITE;
                    wr_en_d  = 1'b1;
                    wr_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt + INIT_W'(1);
                end
            end
            ST_WRITE: begin
                if (wr_acc_c) begin
                    wr_cnt_d  = wr_cnt + CNT_W'(1);
                    wr_data_d = wr_data + DATA_W'(1);
                    if (32'(wr_cnt) == BURST_LEN - 32'd1) begin
                        wr_en_d    = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (32'(fifo.rd_water_level) >= BURST_LEN) begin
                    state_d  = ST_READ;
                    rd_en_d  = 1'b1;
                    rd_cnt_d = '0;
                end else if (32'(wait_cnt) + 32'd1 >= TIMEOUT) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt + TIM_W'(1);
                end
            end
            ST_READ: begin
                if (rd_acc_c) begin
                    rd_cnt_d = rd_cnt + CNT_W'(1);
                    if (32'(rd_cnt) == BURST_LEN - 32'd1) begin
                        rd_en_d = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The final compare lands this cycle, so pass must see its mismatch.
                round_cnt_d = round_cnt + RND_W'(1);
                if ((ROUNDS != 0) && (32'(round_cnt) + 32'd1 >= ROUNDS)) begin
                    done_d  = 1'b1;
                    pass_d  = (err_cnt == '0) && !mismatch_c;
                    state_d = ST_DONE;
                end else begin
                    wr_en_d  = 1'b1;
                    wr_cnt_d = '0;
                    state_d  = ST_WRITE;
                end
            end
            ST_DONE: begin
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            init_cnt  <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wait_cnt  <= '0;
            round_cnt <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            chk_vld   <= 1'b0;
            exp_data  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            init_cnt  <= init_cnt_d;
            wr_cnt    <= wr_cnt_d;
            rd_cnt    <= rd_cnt_d;
            wait_cnt  <= wait_cnt_d;
            round_cnt <= round_cnt_d;
            wr_en     <= wr_en_d;
            wr_data   <= wr_data_d;
            rd_en     <= rd_en_d;
            chk_vld   <= chk_vld_d;
            exp_data  <= exp_data_d;
            done      <= done_d;
            pass      <= pass_d;
            timeout   <= timeout_d;
        end
    end

    fifo_data_checker u_checker (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .chk_vld    (chk_vld),
        .rd_data    (fifo.rd_data),
        .exp_data   (exp_data),
        .mismatch_c (mismatch_c),
        .err_cnt    (err_cnt),
        .first_err  (first_err_rec)
    );

endmodule

// File: tb/tb_fifo_test_gen.sv
// Bench for fifo_test_gen: behavioural FIFO with fault knobs plus a stream-level
// reference of the expected write pattern and error outcome.
module tb_fifo_test_gen;
    import fifo_test_pkg::*;

    localparam int BURST_LEN = 256;
    localparam int ROUNDS    = 2;
    localparam int INIT_WAIT = 16;
    localparam int TIMEOUT   = 1024;
    localparam int DEPTH     = 256;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    logic done, pass, timeout;
    logic [ERR_W-1:0]    err_cnt;
    logic [2*DATA_W-1:0] first_err;

    int vec  = 0;
    int errs = 0;

    fifo_test_gen_if bif();

    fifo_test_gen #(
        .BURST_LEN (BURST_LEN),
        .ROUNDS    (ROUNDS),
        .INIT_WAIT (INIT_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .fifo      (bif),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural FIFO and its fault knobs.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd_data = '0;
    logic [DATA_W-1:0] m_v;
    int  occ = 0;
    int  rd_idx = 0;
    int  corrupt_at = -1;
    logic tog = 1'b0;
    bit  force_full = 1'b0, hold_lvl0 = 1'b0, tog_en = 1'b0, rand_en = 1'b0;
    bit  rnd_full = 1'b0, rnd_empty = 1'b0;

    assign bif.wr_full        = (occ >= DEPTH) || force_full || rnd_full;
    assign bif.rd_empty       = (occ == 0) || (tog_en && tog) || rnd_empty;
    assign bif.rd_data        = m_rd_data;
    assign bif.rd_water_level = hold_lvl0 ? '0 : LVL_W'(occ);

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            rd_idx = 0;
            occ       <= 0;
            m_rd_data <= '0;
            tog       <= 1'b0;
        end else begin
            if (bif.wr_en && !bif.wr_full) q.push_back(bif.wr_data);
            if (bif.rd_en && !bif.rd_empty) begin
                m_v = q.pop_front();
                if (rd_idx == corrupt_at) m_v = 8'hAA;
                rd_idx = rd_idx + 1;
                m_rd_data <= m_v;
            end
            occ <= q.size();
            tog <= ~tog;
        end
    end

    always @(posedge sys_clk) begin
        #1;
        rnd_full  = rand_en && ($urandom_range(0, 3) == 0);
        rnd_empty = rand_en && ($urandom_range(0, 3) == 0);
    end

    // Transaction monitor, sampled mid-cycle.
    int cyc = 0;
    logic [DATA_W-1:0] wr_log[$];
    int n_rd = 0, n_rd_en = 0, n_both = 0, wr_at_rd = -1, last_wr_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            wr_log.delete();
            n_rd = 0; n_rd_en = 0; n_both = 0; wr_at_rd = -1; last_wr_cyc = 0;
        end else begin
            if (bif.wr_en && !bif.wr_full) begin
                wr_log.push_back(bif.wr_data);
                last_wr_cyc = cyc;
            end
            if (bif.rd_en && !bif.rd_empty) begin
                if (n_rd == 0) wr_at_rd = wr_log.size();
                n_rd = n_rd + 1;
            end
            if (bif.rd_en) n_rd_en = n_rd_en + 1;
            if (bif.wr_en && bif.rd_en) n_both = n_both + 1;
        end
    end

    // Reference: the k-th accepted write since reset must carry byte k mod 256.
    function automatic int seq_bad_idx();
        for (int i = 0; i < wr_log.size(); i++)
            if (wr_log[i] !== 8'(i)) return i;
        return -1;
    endfunction

    task automatic apply_reset();
        @(posedge sys_clk); #1;
        rst_n = 1'b0;
        force_full = 1'b0; hold_lvl0 = 1'b0; tog_en = 1'b0; rand_en = 1'b0; corrupt_at = -1;
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic count_to_wr_en(output int n);
        n = 0;
        while (n < 100 && !bif.wr_en) begin
            @(posedge sys_clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        @(posedge sys_clk); #1;
        rst_n = 1'b0;
        #1;
        vec++; if (bif.wr_en !== 1'b0)   begin errs++; $display("FAIL rst_wr_en got %b want 0", bif.wr_en); end
        vec++; if (bif.rd_en !== 1'b0)   begin errs++; $display("FAIL rst_rd_en got %b want 0", bif.rd_en); end
        vec++; if (bif.wr_data !== 8'h00) begin errs++; $display("FAIL rst_wr_data got %h want 00", bif.wr_data); end
        vec++; if (done !== 1'b0)        begin errs++; $display("FAIL rst_done got %b want 0", done); end
        vec++; if (pass !== 1'b0)        begin errs++; $display("FAIL rst_pass got %b want 0", pass); end
        vec++; if (timeout !== 1'b0)     begin errs++; $display("FAIL rst_timeout got %b want 0", timeout); end
        vec++; if (err_cnt !== 16'h0)    begin errs++; $display("FAIL rst_err_cnt got %h want 0", err_cnt); end
        vec++; if (first_err !== 16'h0)  begin errs++; $display("FAIL rst_first_err got %h want 0", first_err); end
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        count_to_wr_en(n);
        vec++; if (n != INIT_WAIT) begin errs++; $display("FAIL init_wait got %0d want %0d", n, INIT_WAIT); end
        vec++; if (bif.wr_data !== 8'h00) begin errs++; $display("FAIL first_wr_data got %h want 00", bif.wr_data); end
    endtask

    task automatic test_ideal();
        bit ok;
        int bad;
        apply_reset();
        wait_done(5000, ok);
        bad = seq_bad_idx();
        vec++; if (!ok)                 begin errs++; $display("FAIL ideal_done got 0 want 1"); end
        vec++; if (pass !== 1'b1)       begin errs++; $display("FAIL ideal_pass got %b want 1", pass); end
        vec++; if (err_cnt !== 16'h0)   begin errs++; $display("FAIL ideal_err_cnt got %h want 0", err_cnt); end
        vec++; if (timeout !== 1'b0)    begin errs++; $display("FAIL ideal_timeout got %b want 0", timeout); end
        vec++; if (wr_log.size() != ROUNDS*BURST_LEN) begin errs++; $display("FAIL ideal_wr_count got %0d want %0d", wr_log.size(), ROUNDS*BURST_LEN); end
        vec++; if (bad != -1) begin errs++; $display("FAIL ideal_wr_seq idx %0d got %h want %h", bad, wr_log[bad], 8'(bad)); end
        vec++; if (n_rd != ROUNDS*BURST_LEN) begin errs++; $display("FAIL ideal_rd_count got %0d want %0d", n_rd, ROUNDS*BURST_LEN); end
        vec++; if (n_both != 0) begin errs++; $display("FAIL ideal_wr_rd_overlap got %0d want 0", n_both); end
    endtask

    task automatic test_stall();
        bit ok, found;
        int bad;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge sys_clk); #1;
            if (bif.wr_en && bif.wr_data == 8'h40) begin found = 1'b1; break; end
        end
        vec++; if (!found) begin errs++; $display("FAIL stall_reach_40 got 0 want 1"); end
        force_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            vec++; if (bif.wr_data !== 8'h40) begin errs++; $display("FAIL stall_hold cyc %0d got %h want 40", i, bif.wr_data); end
        end
        force_full = 1'b0;
        wait_done(5000, ok);
        bad = seq_bad_idx();
        vec++; if (!ok)                  begin errs++; $display("FAIL stall_done got 0 want 1"); end
        vec++; if (wr_at_rd != BURST_LEN) begin errs++; $display("FAIL stall_burst_writes got %0d want %0d", wr_at_rd, BURST_LEN); end
        vec++; if (bad != -1) begin errs++; $display("FAIL stall_wr_seq idx %0d got %h want %h", bad, wr_log[bad], 8'(bad)); end
        vec++; if (pass !== 1'b1)        begin errs++; $display("FAIL stall_pass got %b want 1", pass); end
    endtask

    task automatic test_random_backpressure();
        bit ok;
        int bad;
        apply_reset();
        rand_en = 1'b1;
        wait_done(8000, ok);
        rand_en = 1'b0;
        bad = seq_bad_idx();
        vec++; if (!ok)               begin errs++; $display("FAIL rand_done got 0 want 1"); end
        vec++; if (bad != -1) begin errs++; $display("FAIL rand_wr_seq idx %0d got %h want %h", bad, wr_log[bad], 8'(bad)); end
        vec++; if (n_rd != ROUNDS*BURST_LEN) begin errs++; $display("FAIL rand_rd_count got %0d want %0d", n_rd, ROUNDS*BURST_LEN); end
        vec++; if (n_both != 0)       begin errs++; $display("FAIL rand_wr_rd_overlap got %0d want 0", n_both); end
        vec++; if (err_cnt !== 16'h0) begin errs++; $display("FAIL rand_err_cnt got %h want 0", err_cnt); end
        vec++; if (pass !== 1'b1)     begin errs++; $display("FAIL rand_pass got %b want 1", pass); end
    endtask

    task automatic test_corrupt();
        bit ok;
        int idx;
        logic [ERR_W-1:0]    exp_err;
        logic [2*DATA_W-1:0] exp_first;
        for (int k = 0; k < 2; k++) begin
            idx = (k == 0) ? 10 : int'($urandom_range(BURST_LEN, ROUNDS*BURST_LEN - 1));
            apply_reset();
            corrupt_at = idx;
            // Read index idx is expected to carry byte idx mod 256; 0xAA at that slot is not an error.
            exp_err   = (8'(idx) != 8'hAA) ? 16'd1 : 16'd0;
            exp_first = (exp_err != 0) ? {8'(idx), 8'hAA} : 16'h0;
            wait_done(5000, ok);
            vec++; if (!ok)                  begin errs++; $display("FAIL corrupt_done idx %0d got 0 want 1", idx); end
            vec++; if (err_cnt !== exp_err)  begin errs++; $display("FAIL corrupt_err_cnt idx %0d got %h want %h", idx, err_cnt, exp_err); end
            vec++; if (first_err !== exp_first) begin errs++; $display("FAIL corrupt_first_err idx %0d got %h want %h", idx, first_err, exp_first); end
            vec++; if (pass !== (exp_err == 0)) begin errs++; $display("FAIL corrupt_pass idx %0d got %b want %b", idx, pass, (exp_err == 0)); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int waited;
        apply_reset();
        hold_lvl0 = 1'b1;
        wait_done(3000, ok);
        waited = cyc - last_wr_cyc;
        vec++; if (!ok)              begin errs++; $display("FAIL to_done got 0 want 1"); end
        vec++; if (timeout !== 1'b1) begin errs++; $display("FAIL to_timeout got %b want 1", timeout); end
        vec++; if (pass !== 1'b0)    begin errs++; $display("FAIL to_pass got %b want 0", pass); end
        vec++; if (n_rd_en != 0)     begin errs++; $display("FAIL to_rd_en_cycles got %0d want 0", n_rd_en); end
        vec++; if (waited != TIMEOUT + 1) begin errs++; $display("FAIL to_latency got %0d want %0d", waited, TIMEOUT + 1); end
        vec++; if (wr_log.size() != BURST_LEN) begin errs++; $display("FAIL to_wr_count got %0d want %0d", wr_log.size(), BURST_LEN); end
    endtask

    task automatic test_empty_toggle();
        bit ok;
        apply_reset();
        tog_en = 1'b1;
        wait_done(6000, ok);
        vec++; if (!ok)               begin errs++; $display("FAIL tog_done got 0 want 1"); end
        vec++; if (n_rd != ROUNDS*BURST_LEN) begin errs++; $display("FAIL tog_rd_count got %0d want %0d", n_rd, ROUNDS*BURST_LEN); end
        vec++; if (err_cnt !== 16'h0) begin errs++; $display("FAIL tog_err_cnt got %h want 0", err_cnt); end
        vec++; if (pass !== 1'b1)     begin errs++; $display("FAIL tog_pass got %b want 1", pass); end
    endtask

    task automatic test_reset_mid_read();
        bit ok, found;
        int n, bad;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge sys_clk); #1;
            if (n_rd >= 100) begin found = 1'b1; break; end
        end
        vec++; if (!found) begin errs++; $display("FAIL mid_reach_read got 0 want 1"); end
        rst_n = 1'b0;
        #1;
        vec++; if (bif.rd_en !== 1'b0)    begin errs++; $display("FAIL mid_rd_en got %b want 0", bif.rd_en); end
        vec++; if (bif.wr_data !== 8'h00) begin errs++; $display("FAIL mid_wr_data got %h want 00", bif.wr_data); end
        vec++; if (done !== 1'b0)         begin errs++; $display("FAIL mid_done got %b want 0", done); end
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        count_to_wr_en(n);
        vec++; if (n != INIT_WAIT)        begin errs++; $display("FAIL mid_init_wait got %0d want %0d", n, INIT_WAIT); end
        vec++; if (bif.wr_data !== 8'h00) begin errs++; $display("FAIL mid_restart_data got %h want 00", bif.wr_data); end
        wait_done(5000, ok);
        bad = seq_bad_idx();
        vec++; if (!ok)            begin errs++; $display("FAIL mid_done_final got 0 want 1"); end
        vec++; if (bad != -1) begin errs++; $display("FAIL mid_wr_seq idx %0d got %h want %h", bad, wr_log[bad], 8'(bad)); end
        vec++; if (pass !== 1'b1)  begin errs++; $display("FAIL mid_pass got %b want 1", pass); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stall();
        test_random_backpressure();
        test_corrupt();
        test_timeout();
        test_empty_toggle();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/fifo_test_gen.md
# fifo_test_gen

Self-checking traffic generator for the FIFO test top: drives the write port with an incrementing byte pattern, then drains the read port and compares every returned byte against the expected sequence. It sits beside the FIFO test top on the same `sys_clk` and owns `wr_en`, `wr_data` and `rd_en`. It reports pass/fail, error count and completion for the board LEDs and the simulation bench.

## Interface
- `BURST_LEN`, 256: words written, then read, per round (1..DEPTH).
- `ROUNDS`, 4: number of write/read rounds; 0 means run forever, and `done` is never asserted.
- `INIT_WAIT`, 16: cycles held in IDLE after reset release, for FIFO reset recovery.
- `TIMEOUT`, 1024: maximum cycles in WAIT before a timeout failure.
- `sys_clk`  in  1  single clock; also clocks both FIFO ports.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  out  1  FIFO write request.
- `wr_data`  out  8  write data, the pattern counter.
- `wr_full`  in  1  FIFO full; a write is accepted only when `wr_en && !wr_full`.
- `rd_en`  out  1  FIFO read request.
- `rd_data`  in  8  FIFO read data, valid one cycle after an accepted read.
- `rd_empty`  in  1  FIFO empty; a read is accepted only when `rd_en && !rd_empty`.
- `rd_water_level`  in  9  FIFO read-side occupancy.
- `done`  out  1  all rounds finished, or a timeout occurred.
- `pass`  out  1  `done && err_cnt==0 && !timeout`.
- `timeout`  out  1  sticky; WAIT exceeded `TIMEOUT`.
- `err_cnt`  out  16  mismatch count; saturates at 0xFFFF.
- `first_err`  out  16  {expected, received} of the first mismatch.

## Operation
- FSM states: IDLE, WRITE, WAIT, READ, DRAIN, DONE.
- IDLE: count `INIT_WAIT` cycles, then go to WRITE.
- WRITE
  - `wr_en=1` while `wr_cnt < BURST_LEN`.
  - On each accepted write, `wr_data` and `wr_cnt` increment; `wr_data` wraps 0xFF→0x00.
  - A cycle with `wr_en && wr_full` holds `wr_data` and `wr_cnt` unchanged and is retried.
  - When the last word is accepted, `wr_en` drops the next cycle and the FSM goes to WAIT.
- WAIT
  - Go to READ when `rd_water_level >= BURST_LEN`.
  - If the wait counter reaches `TIMEOUT`, set `timeout` and go to DONE.
- READ
  - `rd_en=1` while `rd_cnt < BURST_LEN`; `rd_cnt` increments on each accepted read.
  - Accepted reads push a 1-cycle valid pipeline, `chk_vld`.
  - On `chk_vld`: compare `rd_data` with `exp_data`, then `exp_data++` (wraps at 0xFF).
  - On a mismatch: `err_cnt++`. Capture `first_err` only when `err_cnt==0`.
- DRAIN: one cycle, so the last compare completes. Then increment the round counter.
  - If rounds remain (or `ROUNDS==0`), go to WRITE.
  - Otherwise go to DONE.
- DONE: terminal. All requests are held low; only reset exits.
- The pattern continues across rounds: `wr_data` and `exp_data` are not reset between rounds.

## Timing
- Reset values
  - All outputs 0: `wr_en`, `rd_en`, `done`, `pass`, `timeout`, `err_cnt`, `first_err`; `wr_data=0x00`.
  - `exp_data=0x00`, FSM state IDLE.
- Outputs are registered; FSM transitions take effect on the clock edge.
- Write is accepted in the same cycle as `wr_en && !wr_full`.
- Read data arrives 1 cycle after an accepted read; the compare happens in that cycle.
- `wr_en` and `rd_en` are never asserted in the same cycle.
- `rd_en` is asserted during empty cycles but not counted; `rd_data` is ignored unless `chk_vld`.
- `done` and `pass` assert on the cycle of DONE entry; they remain stable until reset.
- Reset mid-round: all state clears asynchronously; the sequence restarts from IDLE with pattern 0x00.

## Structure
- Shared package `fifo_test_pkg` (define header) holds:
  - the FSM state encodings (3-bit);
  - `DATA_W=8`, `LVL_W=9`;
  - the error-counter width.
- Sub-module `fifo_data_checker` takes `chk_vld`, `rd_data` and `exp_data`, and owns `err_cnt` saturation and the `first_err` capture.
- The FSM and counters stay in the top of this block.

## Test plan
- Ideal FIFO model, `BURST_LEN=256`, `ROUNDS=2`:
  - `wr_data` runs 0x00..0xFF, then 0x00..0xFF again.
  - `done=1`, `pass=1`, `err_cnt=0`.
- `wr_full` forced high for 5 cycles mid-burst at `wr_data=0x40`:
  - `wr_data` stays 0x40 during the stall.
  - Exactly 256 writes are accepted.
  - `pass=1`.
- Model corrupts read word 10 (returns 0xAA, expected 0x0A):
  - `err_cnt=1`, `first_err=0x0AAA`, `pass=0`, `done=1`.
- `rd_water_level` held at 0 after WRITE:
  - `timeout=1` and `done=1` after 1024 WAIT cycles.
  - `pass=0`; `rd_en` is never asserted.
- `rd_empty` toggled every other cycle during READ:
  - 256 accepted reads, no false errors, `pass=1`.
- `rst_n` pulsed low during READ of round 1:
  - Outputs clear immediately.
  - Restart writes 0x00 after `INIT_WAIT`, then completes with `pass=1`.
